// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
package div_ctrl_pkg;

  localparam int DIV_XLEN = 32;

  // Quotient returned for any divide-by-zero.
  localparam logic [DIV_XLEN-1:0] DIV_ZERO_Q       = '1;
  // Most negative dividend; with a divisor of -1 it overflows a signed divide.
  localparam logic [DIV_XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } div_state_e;

  // REM and REMU write back the remainder; DIV and DIVU the quotient.
  function automatic logic is_rem(div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_fastpath.sv
// Resolves requests that never need the serial divider: divide-by-zero,
// signed overflow, and a repeat of the last divider operands.
module div_fastpath
  import div_ctrl_pkg::*;
#(
  parameter int XLEN     = DIV_XLEN,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_signed,
  input  logic            i_cacheValid,
  input  logic [XLEN-1:0] i_cacheRs1,
  input  logic [XLEN-1:0] i_cacheRs2,
  input  logic            i_cacheSigned,
  input  logic [XLEN-1:0] i_cacheQ,
  input  logic [XLEN-1:0] i_cacheR,
  output logic            o_hit,
  output logic [XLEN-1:0] o_q,
  output logic [XLEN-1:0] o_r
);

  logic w_divZero;
  logic w_overflow;
  logic w_cacheHit;

  // Special cases take priority over the cache since their results are fixed.
  always_comb begin
    w_divZero  = (i_rs2 == '0);
    w_overflow = i_signed && (i_rs1 == DIV_OVF_DIVIDEND) && (i_rs2 == '1);
    w_cacheHit = CACHE_EN && i_cacheValid && (i_rs1 == i_cacheRs1) &&
                 (i_rs2 == i_cacheRs2) && (i_signed == i_cacheSigned);
    o_hit = w_divZero || w_overflow || w_cacheHit;
    o_q   = '0;
    o_r   = '0;
    if (w_divZero) begin
      o_q = DIV_ZERO_Q;
      o_r = i_rs1;
    end else if (w_overflow) begin
      o_q = DIV_OVF_DIVIDEND;
      o_r = '0;
    end else if (w_cacheHit) begin
      o_q = i_cacheQ;
      o_r = i_cacheR;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues RV32IM DIV/DIVU/REM/REMU to the shared serial divider, answers
// special cases and repeated operands locally, and drives the EX stall.
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN     = DIV_XLEN,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_div_start,
  output logic            o_div_flush,
  output logic            o_div_signed,
  output logic [XLEN-1:0] o_div_dividend,
  output logic [XLEN-1:0] o_div_divisor,
  input  logic            i_div_busy,
  input  logic            i_div_end_valid,
  input  logic [XLEN-1:0] i_div_quotient,
  input  logic [XLEN-1:0] i_div_remainder
);

  div_state_e      r_state;
  div_state_e      w_nextState;
  div_op_e         r_op;
  logic [4:0]      r_rd;
  logic            r_signed;
  logic [XLEN-1:0] r_dividend;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_r;

  logic            r_cacheValid;
  logic [XLEN-1:0] r_cacheRs1;
  logic [XLEN-1:0] r_cacheRs2;
  logic            r_cacheSigned;
  logic [XLEN-1:0] r_cacheQ;
  logic [XLEN-1:0] r_cacheR;

  logic            w_reqSigned;
  logic            w_accept;
  logic            w_capture;
  logic            w_fastHit;
  logic [XLEN-1:0] w_fastQ;
  logic [XLEN-1:0] w_fastR;

  assign w_reqSigned = ~i_op[0];
  assign w_accept    = (r_state == IDLE) && i_req && !i_flush;
  // A result arriving together with a flush belongs to a killed op.
  assign w_capture   = (r_state == WAIT) && i_div_end_valid && !i_flush;

  assign o_div_signed   = r_signed;
  assign o_div_dividend = r_dividend;
  assign o_div_divisor  = r_divisor;

  div_fastpath #(
    .XLEN     (XLEN),
    .CACHE_EN (CACHE_EN)
  ) u_fastpath (
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .i_signed      (w_reqSigned),
    .i_cacheValid  (r_cacheValid),
    .i_cacheRs1    (r_cacheRs1),
    .i_cacheRs2    (r_cacheRs2),
    .i_cacheSigned (r_cacheSigned),
    .i_cacheQ      (r_cacheQ),
    .i_cacheR      (r_cacheR),
    .o_hit         (w_fastHit),
    .o_q           (w_fastQ),
    .o_r           (w_fastR)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next state and all control outputs; results are only driven in DONE.
  always_comb begin
    w_nextState = r_state;
    o_stall     = 1'b0;
    o_wb_valid  = 1'b0;
    o_wb_rd     = '0;
    o_wb_data   = '0;
    o_div_start = 1'b0;
    o_div_flush = 1'b0;
    case (r_state)
      IDLE: begin
        o_stall = i_req && !i_flush;
        if (w_accept) w_nextState = w_fastHit ? DONE : START;
      end
      START: begin
        o_stall = 1'b1;
        if (i_flush) begin
          w_nextState = IDLE;
        end else if (!i_div_busy) begin
          o_div_start = 1'b1;
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        o_stall = 1'b1;
        if (i_flush) begin
          o_div_flush = 1'b1;
          w_nextState = IDLE;
        end else if (i_div_end_valid) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
        if (!i_flush) begin
          o_wb_valid = 1'b1;
          o_wb_rd    = r_rd;
          o_wb_data  = is_rem(r_op) ? r_r : r_q;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Latch the accepted request and its result, fast-path or from the divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= DIV;
      r_rd       <= '0;
      r_signed   <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_q        <= '0;
      r_r        <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= div_op_e'(i_op);
        r_rd       <= i_rd;
        r_signed   <= w_reqSigned;
        r_dividend <= i_rs1;
        r_divisor  <= i_rs2;
        r_q        <= w_fastQ;
        r_r        <= w_fastR;
      end
      if (w_capture) begin
        r_q <= i_div_quotient;
        r_r <= i_div_remainder;
      end
    end
  end

  // Remember the last completed divider operands so a DIV/REM pair divides once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cacheValid  <= 1'b0;
      r_cacheRs1    <= '0;
      r_cacheRs2    <= '0;
      r_cacheSigned <= 1'b0;
      r_cacheQ      <= '0;
      r_cacheR      <= '0;
    end else if (CACHE_EN && w_capture) begin
      r_cacheValid  <= 1'b1;
      r_cacheRs1    <= r_dividend;
      r_cacheRs2    <= r_divisor;
      r_cacheSigned <= r_signed;
      r_cacheQ      <= i_div_quotient;
      r_cacheR      <= i_div_remainder;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural serdiv model.
module tb_div_issue_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [1:0]  i_op;
  logic [31:0] i_rs1, i_rs2;
  logic [4:0]  i_rd;
  logic        i_flush;
  logic        o_stall, o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_div_start, o_div_flush, o_div_signed;
  logic [31:0] o_div_dividend, o_div_divisor;
  logic        i_div_busy, i_div_end_valid;
  logic [31:0] i_div_quotient, i_div_remainder;

  int compared = 0;
  int mismatched = 0;
  int divLatency = 33;
  int startCount = 0;
  int startViolations = 0;
  int sdCnt = 0;
  int sdDrain = 0;
  logic [31:0] sdA, sdB;
  logic        sdSigned;

  logic        refCacheValid;
  logic [31:0] refCacheA, refCacheB;
  logic        refCacheSigned;

  always #5 clk = ~clk;

  div_issue_ctrl #(.XLEN(32), .CACHE_EN(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_req           (i_req),
    .i_op            (i_op),
    .i_rs1           (i_rs1),
    .i_rs2           (i_rs2),
    .i_rd            (i_rd),
    .i_flush         (i_flush),
    .o_stall         (o_stall),
    .o_wb_valid      (o_wb_valid),
    .o_wb_rd         (o_wb_rd),
    .o_wb_data       (o_wb_data),
    .o_div_start     (o_div_start),
    .o_div_flush     (o_div_flush),
    .o_div_signed    (o_div_signed),
    .o_div_dividend  (o_div_dividend),
    .o_div_divisor   (o_div_divisor),
    .i_div_busy      (i_div_busy),
    .i_div_end_valid (i_div_end_valid),
    .i_div_quotient  (i_div_quotient),
    .i_div_remainder (i_div_remainder)
  );

  // RISC-V M-extension result for one instruction, straight from the ISA rules.
  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic [31:0] q, r;
    sgn = ~op[0];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // The divider is needed unless the result is special or was the last one computed.
  function automatic bit refExpectStart(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    bit special, hit;
    sgn = ~op[0];
    special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit = refCacheValid && a == refCacheA && b == refCacheB && sgn == refCacheSigned;
    return !special && !hit;
  endfunction

  // Serial divider model: fixed latency, aborts on flush and stays busy while draining.
  always @(posedge clk) begin
    if (reset) begin
      i_div_busy <= 1'b0; i_div_end_valid <= 1'b0;
      i_div_quotient <= '0; i_div_remainder <= '0;
      sdCnt <= 0; sdDrain <= 0;
    end else begin
      i_div_end_valid <= 1'b0;
      if (o_div_start) startCount <= startCount + 1;
      if (o_div_start && i_div_busy) startViolations <= startViolations + 1;
      if (o_div_flush) begin
        sdCnt <= 0; sdDrain <= 4; i_div_busy <= 1'b1;
      end else if (o_div_start) begin
        sdCnt <= divLatency - 1; sdA <= o_div_dividend; sdB <= o_div_divisor;
        sdSigned <= o_div_signed; i_div_busy <= 1'b1;
      end else if (sdCnt == 1) begin
        sdCnt <= 0; i_div_end_valid <= 1'b1; i_div_busy <= 1'b0;
        i_div_quotient  <= refResult(sdSigned ? 2'b00 : 2'b01, sdA, sdB);
        i_div_remainder <= refResult(sdSigned ? 2'b10 : 2'b11, sdA, sdB);
      end else if (sdCnt > 1) begin
        sdCnt <= sdCnt - 1;
      end else if (sdDrain > 0) begin
        sdDrain <= sdDrain - 1; i_div_busy <= (sdDrain > 1);
      end
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " o_stall"}, 32'(o_stall), 32'd0);
    checkOutput({tag, " o_wb_valid"}, 32'(o_wb_valid), 32'd0);
    checkOutput({tag, " o_wb_rd"}, 32'(o_wb_rd), 32'd0);
    checkOutput({tag, " o_wb_data"}, o_wb_data, 32'd0);
    checkOutput({tag, " o_div_start"}, 32'(o_div_start), 32'd0);
    checkOutput({tag, " o_div_flush"}, 32'(o_div_flush), 32'd0);
    checkOutput({tag, " o_div_signed"}, 32'(o_div_signed), 32'd0);
    checkOutput({tag, " o_div_dividend"}, o_div_dividend, 32'd0);
    checkOutput({tag, " o_div_divisor"}, o_div_divisor, 32'd0);
  endtask

  // Issue one instruction, hold it until writeback, and check result, timing and divider use.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expData, input bit expStart,
                               input int expLat, input string name);
    int startsBefore, cycles, stallDrops;
    bit done;
    @(negedge clk);
    i_req = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_rd = rd; i_flush = 1'b0;
    startsBefore = startCount;
    #1;
    checkOutput({name, " stall at accept"}, 32'(o_stall), 32'd1);
    cycles = 0; stallDrops = 0; done = 1'b0;
    while (!done && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (o_wb_valid) done = 1'b1;
      else if (o_stall !== 1'b1) stallDrops++;
    end
    checkOutput({name, " wb_valid seen"}, 32'(done), 32'd1);
    if (done) begin
      checkOutput({name, " wb_data"}, o_wb_data, expData);
      checkOutput({name, " wb_rd"}, 32'(o_wb_rd), 32'(rd));
      checkOutput({name, " stall in DONE"}, 32'(o_stall), 32'd0);
      checkOutput({name, " stall drops before DONE"}, 32'(stallDrops), 32'd0);
      checkOutput({name, " div_start count"}, 32'(startCount - startsBefore), 32'(expStart));
      checkOutput({name, " start while busy"}, 32'(startViolations), 32'd0);
      if (expLat > 0) checkOutput({name, " latency"}, 32'(cycles), 32'(expLat));
      if (expStart) begin
        refCacheValid = 1'b1; refCacheA = a; refCacheB = b; refCacheSigned = ~op[0];
      end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] expData;
    bit          expStart;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int startsBefore, wbSeen;
    logic [1:0] rop;
    logic [31:0] ra, rb, prevA, prevB;
    int mode;
    bit es;

    vecs[0] = '{DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 1'b1, "divu 100/7"};
    vecs[1] = '{DIV, 32'hFFFF_FF9C, 32'd7, 5'd2, 32'hFFFF_FFF2, 1'b1, "div -100/7"};
    vecs[2] = '{REM, 32'hFFFF_FF9C, 32'd7, 5'd3, 32'hFFFF_FFFE, 1'b0, "rem -100/7 cached"};
    vecs[3] = '{DIV, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b0, "div by zero"};
    vecs[4] = '{REMU, 32'd5, 32'd0, 5'd5, 32'd5, 1'b0, "remu by zero"};
    vecs[5] = '{DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 1'b0, "div overflow"};
    vecs[6] = '{REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0, 1'b0, "rem overflow"};
    vecs[7] = '{DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1'b1, "divu big/max"};

    reset = 1'b1; i_req = 1'b0; i_op = 2'b00; i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_flush = 1'b0;
    refCacheValid = 1'b0; refCacheA = '0; refCacheB = '0; refCacheSigned = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    // Flush in IDLE must not accept the request.
    @(negedge clk);
    startsBefore = startCount;
    i_req = 1'b1; i_op = DIVU; i_rs1 = 32'd9; i_rs2 = 32'd3; i_flush = 1'b1;
    #1;
    checkOutput("idle flush stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    i_req = 1'b0; i_flush = 1'b0;
    #1;
    checkOutput("idle flush no accept", 32'(o_stall), 32'd0);
    checkOutput("idle flush no wb", 32'(o_wb_valid), 32'd0);
    checkOutput("idle flush no start", 32'(startCount - startsBefore), 32'd0);

    divLatency = 33;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].expData,
                    vecs[i].expStart, vecs[i].expStart ? divLatency + 2 : 1, vecs[i].name);
    end
    applyStimulus(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1'b0, 1, "remu big/max cached");

    // Flush ten cycles into WAIT, then re-issue while serdiv is still draining.
    @(negedge clk);
    startsBefore = startCount;
    i_req = 1'b1; i_op = DIVU; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_rd = 5'd10;
    repeat (11) @(negedge clk);
    checkOutput("wait dividend", o_div_dividend, 32'd1000);
    checkOutput("wait divisor", o_div_divisor, 32'd3);
    checkOutput("wait signed", 32'(o_div_signed), 32'd0);
    i_flush = 1'b1;
    #1;
    checkOutput("wait flush pulse", 32'(o_div_flush), 32'd1);
    checkOutput("wait flush no wb", 32'(o_wb_valid), 32'd0);
    @(negedge clk);
    i_flush = 1'b0; i_req = 1'b0;
    #1;
    checkOutput("after flush idle", 32'(o_stall), 32'd0);
    checkOutput("after flush no wb", 32'(o_wb_valid), 32'd0);
    checkOutput("after flush flush low", 32'(o_div_flush), 32'd0);
    checkOutput("flushed op starts", 32'(startCount - startsBefore), 32'd1);
    applyStimulus(DIVU, 32'd1000, 32'd3, 5'd11, 32'd333, 1'b1, divLatency + 4, "divu 1000/3 reissue");

    // Reset in the middle of a divide clears everything, including the cache.
    @(negedge clk);
    i_req = 1'b1; i_op = DIV; i_rs1 = 32'd77; i_rs2 = 32'd5; i_rd = 5'd12;
    repeat (7) @(negedge clk);
    checkOutput("midwait stall", 32'(o_stall), 32'd1);
    reset = 1'b1; i_req = 1'b0;
    @(negedge clk);
    checkAllZero("reset midwait");
    reset = 1'b0;
    refCacheValid = 1'b0;
    wbSeen = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_wb_valid) wbSeen++;
    end
    checkOutput("no wb after reset", 32'(wbSeen), 32'd0);
    applyStimulus(DIVU, 32'd1000, 32'd3, 5'd13, 32'd333, 1'b1, divLatency + 2, "divu after reset misses");

    // Randomized instructions against the reference model.
    prevA = 32'd1000; prevB = 32'd3;
    for (int n = 0; n < 60; n++) begin
      divLatency = $urandom_range(2, 8);
      rop = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 5);
      case (mode)
        0: begin ra = $urandom; rb = 32'd0; end
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = prevA; rb = prevB; end
        3, 4: begin ra = 32'($urandom_range(0, 500)) - 32'd250; rb = 32'($urandom_range(1, 20)); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      if (rb == 32'd0 && mode != 0) rb = 32'd1;
      prevA = ra; prevB = rb;
      es = refExpectStart(rop, ra, rb);
      applyStimulus(rop, ra, rb, 5'($urandom_range(0, 31)), refResult(rop, ra, rb), es,
                    es ? divLatency + 2 : 1, $sformatf("rand%0d", n));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        i_req = 1'b0;
      end
    end

    @(negedge clk);
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
